// File: rtl/sr_fetch.sv
// ============================================================================
//  Module   : sr_fetch
//  Brief    : schoolRISCV fetch stage, one outstanding req/gnt/rvalid access,
//             valid/ready hand-off to decode, redirect with stale-fetch kill.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imReq,
  output logic [31:0] imAddr,
  input  logic        imGnt,
  input  logic        imRvalid,
  input  logic [31:0] imRdata,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    unique case (state_q)
      S_REQ: begin
        // A redirect in the grant cycle means the granted address is stale.
        if (imGnt) begin
          state_d = S_WAIT;
          kill_d  = redirect;
        end
      end
      S_WAIT: begin
        if (imRvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d    = imRdata;
            instr_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (instrReady || redirect) begin
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redirect) begin
      fetch_pc_d = redirectPc & PC_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC & PC_MASK;
      kill_q     <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Request is held low during reset so nothing is issued before release.
  assign imReq      = (state_q == S_REQ) && !rst;
  assign imAddr     = fetch_pc_q & PC_MASK;
  assign instrValid = (state_q == S_HOLD);
  assign instr      = instr_q;
  assign instrPc    = instr_pc_q;

endmodule

`default_nettype wire
